// File: rtl/bram_loader.sv
// Streams a fixed number of lines into a BRAM, then hands the BRAM over to cyclic playback.
// Optional running XOR checksum of the written lines: define BRAM_LOADER_CHECKSUM_EN.
module bram_loader #(
    parameter  int DATA_WIDTH = 256,
    parameter  int BRAM_DEPTH = 1024,
    localparam int AW         = $clog2(BRAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [AW:0]           load_len,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  write_rdy,
    output logic [AW-1:0]         addr,
    output logic [DATA_WIDTH-1:0] line_in,
    output logic                  we,
    output logic                  en,
    output logic                  generator_mode,
    output logic                  rst_gen_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef BRAM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_ARM  = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(BRAM_DEPTH);

    logic [2:0]            r_state;
    logic [AW:0]           r_len_q;
    logic [AW-1:0]         r_cnt;
    logic [AW-1:0]         r_addr;
    logic [DATA_WIDTH-1:0] r_line;
    logic                  r_we;
    logic                  r_en;
    logic                  r_gen;
    logic                  r_rst_gen;
    logic                  r_done;
    logic                  r_err;

    logic w_ready;
    logic w_accept;
    logic w_last;
    logic w_len_ok;
    logic w_start_ok;

    assign w_ready    = (r_state == S_LOAD) && write_rdy && !abort;
    assign w_accept   = w_ready && s_valid;
    assign w_last     = ({1'b0, r_cnt} == (r_len_q - 1'b1));
    assign w_len_ok   = (load_len != '0) && (load_len <= DEPTH_L);
    // A new load is only honoured from IDLE/RUN; abort always wins.
    assign w_start_ok = !abort && load_start && w_len_ok &&
                        ((r_state == S_IDLE) || (r_state == S_RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_len_q   <= '0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_line    <= '0;
            r_we      <= 1'b0;
            r_en      <= 1'b0;
            r_gen     <= 1'b0;
            r_rst_gen <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_en      <= 1'b0;
            r_rst_gen <= 1'b0;
            r_done    <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_gen   <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_RUN: begin
                        if (load_start) begin
                            if (w_len_ok) begin
                                r_len_q   <= load_len;
                                r_cnt     <= '0;
                                r_err     <= 1'b0;
                                r_gen     <= 1'b0;
                                r_rst_gen <= 1'b1;
                                r_state   <= S_WAIT;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (write_rdy) r_state <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (w_accept) begin
                            r_we   <= 1'b1;
                            r_en   <= 1'b1;
                            r_line <= s_data;
                            r_addr <= r_cnt;
                            // cnt parks on len_q-1 so addr can never run past the last line
                            if (w_last) r_state <= S_ARM;
                            else        r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                    S_ARM: begin
                        r_gen   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_RUN;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [31:0] w_fold;
    logic [31:0] r_csum;

    always_comb begin
        w_fold = '0;
        for (int i = 0; i < DATA_WIDTH/32; i++) w_fold = w_fold ^ s_data[i*32 +: 32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_csum <= '0;
        else if (w_start_ok) r_csum <= '0;
        else if (w_accept)   r_csum <= r_csum ^ w_fold;
    end

    assign checksum = r_csum;
`else
    // Plain build: no checksum state; w_start_ok only feeds the checksum clear.
    logic w_unused;
    assign w_unused = w_start_ok;
`endif

    assign s_ready        = w_ready;
    assign addr           = r_addr;
    assign line_in        = r_line;
    assign we             = r_we;
    assign en             = r_en;
    assign generator_mode = r_gen;
    assign rst_gen_mode   = r_rst_gen;
    assign done           = r_done;
    assign err            = r_err;
    assign busy           = (r_state == S_WAIT) || (r_state == S_LOAD) || (r_state == S_ARM);

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader (small DATA_WIDTH/BRAM_DEPTH to keep boundary loads short).
module tb_bram_loader;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          abort = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          write_rdy = 1'b0;
    logic          s_ready, we, en, generator_mode, rst_gen_mode, busy, done, err;
    logic [AW-1:0] addr;
    logic [DW-1:0] line_in;
`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    bram_loader #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
        .abort(abort), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .write_rdy(write_rdy), .addr(addr), .line_in(line_in), .we(we), .en(en),
        .generator_mode(generator_mode), .rst_gen_mode(rst_gen_mode), .busy(busy),
        .done(done), .err(err)
`ifdef BRAM_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, src_idx = 0, rdy_run = 0;
    int done_cnt = 0, done_cyc = 0, first_we_cyc = 0, last_we_cyc = 0;
    logic [AW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];
    logic          wq_en[$];

    typedef struct {
        logic [AW:0] len;
        int          bp;       // 0 none, 1 write_rdy bursts, 2 s_valid gaps, 3 both
        logic        exp_err;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [DW-1:0] mkdata(input int k);
        return {32'hC0DE0000 + 32'(k), 32'h12345678 ^ (32'(k) * 32'h01010101)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (we) begin
            if (wq_addr.size() == 0) first_we_cyc = cyc;
            wq_addr.push_back(addr);
            wq_data.push_back(line_in);
            wq_en.push_back(en);
            last_we_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic clear_log();
        wq_addr.delete(); wq_data.delete(); wq_en.delete();
        done_cnt = 0; src_idx = 0;
    endtask

    task automatic drive(input int bp);
        if (bp == 1 || bp == 3) begin
            if (rdy_run == 0) begin
                write_rdy = ~write_rdy;
                rdy_run   = $urandom_range(1, 20);
            end
            rdy_run--;
        end else begin
            write_rdy = 1'b1;
        end
        s_valid = (bp >= 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data  = mkdata(src_idx);
        #1;
        if (s_valid && s_ready) src_idx++;
    endtask

    task automatic check_writes(input int len, input int bp);
        int n;
        logic [31:0] cs;
        cs = '0;
        chk("write_count", wq_addr.size(), len);
        n = (wq_addr.size() < len) ? wq_addr.size() : len;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("addr[%0d]", k), wq_addr[k], k);
            chk($sformatf("data[%0d]", k), wq_data[k], mkdata(k));
            chk($sformatf("en[%0d]", k), wq_en[k], 1);
        end
        for (int k = 0; k < len; k++) cs = cs ^ mkdata(k)[63:32] ^ mkdata(k)[31:0];
        if (bp == 0 && n > 0) chk("consecutive", last_we_cyc - first_we_cyc, len - 1);
`ifdef BRAM_LOADER_CHECKSUM_EN
        chk("checksum", checksum, cs);
`else
        if (cs == 32'hFFFF_FFFF) $display("note: checksum pattern saturated");
`endif
    endtask

    task automatic run_load(input logic [AW:0] len, input int bp, input logic exp_err);
        logic pg;
        bit   to;
        clear_log();
        write_rdy = 1'b1; rdy_run = 0; s_valid = 1'b0;
        pg = generator_mode;
        load_start = 1'b1; load_len = len;
        tick();
        load_start = 1'b0;
        chk("rst_gen_pulse", rst_gen_mode, !exp_err);
        chk("gen_after_start", generator_mode, exp_err ? pg : 1'b0);
        chk("err_after_start", err, exp_err);
        to = 1;
        for (int c = 0; c < 2000; c++) begin
            drive(bp);
            tick();
            if (exp_err ? (c >= 10) : (done_cnt != 0)) begin to = 0; break; end
        end
        if (to) chk("load_timeout", 1, 0);
        s_valid = 1'b0; write_rdy = 1'b1;
        tick();
        chk("rst_gen_low", rst_gen_mode, 0);
        chk("busy_end", busy, 0);
        if (exp_err) begin
            chk("illegal_writes", wq_addr.size(), 0);
            chk("illegal_done", done_cnt, 0);
            chk("illegal_gen", generator_mode, pg);
            chk("err_sticky", err, 1);
        end else begin
            check_writes(int'(len), bp);
            chk("done_count", done_cnt, 1);
            chk("done_after_arm", done_cyc, last_we_cyc + 1);
            chk("done_pulse_end", done, 0);
            chk("gen_run", generator_mode, 1);
        end
    endtask

    initial begin
        vecs[0] = '{len: 5'd0,  bp: 0, exp_err: 1'b1};
        vecs[1] = '{len: 5'd17, bp: 0, exp_err: 1'b1};
        vecs[2] = '{len: 5'd4,  bp: 0, exp_err: 1'b0};
        vecs[3] = '{len: 5'd8,  bp: 0, exp_err: 1'b0};
        vecs[4] = '{len: 5'd16, bp: 1, exp_err: 1'b0};
        vecs[5] = '{len: 5'd0,  bp: 0, exp_err: 1'b1};
        vecs[6] = '{len: 5'd1,  bp: 2, exp_err: 1'b0};
        vecs[7] = '{len: 5'd5,  bp: 3, exp_err: 1'b0};

        tick(); tick();
        chk("rst_we", we, 0);           chk("rst_en", en, 0);
        chk("rst_addr", addr, 0);       chk("rst_line", line_in, 0);
        chk("rst_gen", generator_mode, 0); chk("rst_rstgen", rst_gen_mode, 0);
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_err", err, 0);         chk("rst_sready", s_ready, 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) run_load(vecs[v].len, vecs[v].bp, vecs[v].exp_err);

        // abort with cnt=5 of a 10-line load
        clear_log();
        write_rdy = 1'b1; load_start = 1'b1; load_len = 5'd10;
        tick();
        load_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (src_idx == 5) break;
            drive(0);
            tick();
        end
        chk("abort_reach5", src_idx, 5);
        abort = 1'b1; s_valid = 1'b1; s_data = mkdata(5);
        #1;
        chk("abort_sready", s_ready, 0);
        tick();
        abort = 1'b0; s_valid = 1'b0;
        chk("abort_we", we, 0);
        chk("abort_gen", generator_mode, 0);
        chk("abort_busy", busy, 0);
        for (int c = 0; c < 5; c++) tick();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_writes", wq_addr.size(), 5);
        run_load(5'd3, 0, 1'b0);

        // reset asserted mid-load
        clear_log();
        write_rdy = 1'b1; load_start = 1'b1; load_len = 5'd10;
        tick();
        load_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (src_idx == 3) break;
            drive(0);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", we, 0);     chk("mid_rst_en", en, 0);
        chk("mid_rst_addr", addr, 0); chk("mid_rst_line", line_in, 0);
        chk("mid_rst_gen", generator_mode, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        tick();
        clear_log();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin drive(0); tick(); end
        chk("post_rst_done", done_cnt, 0);
        chk("post_rst_writes", wq_addr.size(), 0);
        chk("post_rst_busy", busy, 0);
        run_load(5'd2, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
